// File: rtl/fetch_align_buffer_pkg.sv
// Shared RV32IC fetch types: halfword type, the full-length opcode marker and
// the fill pattern used for the upper half of compressed instructions.
package fetch_align_buffer_pkg;

  typedef logic [15:0] hw_t;

  localparam logic [1:0] RVC_FULL   = 2'b11;
  localparam hw_t        IR_FILL_HW = 16'hffff;

endpackage

// File: rtl/halfword_fifo.sv
// Halfword FIFO: up to FETCH_HW compacted writes and up to 2 reads per cycle,
// with the two head entries exposed for instruction decode.
module halfword_fifo
  import fetch_align_buffer_pkg::*;
#(
  parameter int DEPTH_HW = 8,
  parameter int FETCH_HW = 2,
  localparam int AW = $clog2(DEPTH_HW),
  localparam int CW = AW + 1,
  localparam int NW = $clog2(FETCH_HW + 1)
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [NW-1:0]          push_n,
  input  hw_t  [FETCH_HW-1:0]    push_data,
  input  logic [1:0]             pop_n,
  output hw_t                    h0,
  output hw_t                    h1,
  output logic [CW-1:0]          count,
  output logic [CW-1:0]          free
);

  hw_t  [DEPTH_HW-1:0] mem;
  logic [CW-1:0]       wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + CW'(push_n);
      rd_ptr <= rd_ptr + CW'(pop_n);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int i = 0; i < FETCH_HW; i++) begin
        if (NW'(i) < push_n) mem[wr_ptr[AW-1:0] + AW'(i)] <= push_data[i];
      end
    end
  end

  assign h0    = mem[rd_ptr[AW-1:0]];
  assign h1    = mem[rd_ptr[AW-1:0] + AW'(1)];
  assign count = wr_ptr - rd_ptr;
  assign free  = CW'(DEPTH_HW) - count;

endmodule

// File: rtl/fetch_align_buffer.sv
// Realigns FETCH_HW-halfword fetch blocks into single RV32IC instructions,
// tracking the head PC, the next expected block and the redirect skip count.
module fetch_align_buffer
  import fetch_align_buffer_pkg::*;
#(
  parameter int FETCH_HW = 2,
  parameter int DEPTH_HW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [31:0]           fetch_pc,
  input  logic [FETCH_HW*16-1:0] fetch_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_is_c
);

  localparam int BB = $clog2(FETCH_HW * 2);
  localparam int SW = BB - 1;
  localparam int CW = $clog2(DEPTH_HW) + 1;
  localparam int NW = $clog2(FETCH_HW + 1);

  logic [31:0]         head_pc, expect_pc;
  logic [SW-1:0]       skip;
  hw_t                 h0, h1;
  logic [CW-1:0]       count, free;
  hw_t [FETCH_HW-1:0]  blk, push_data;
  logic [NW-1:0]       push_n;
  logic [1:0]          pop_n;
  logic                accept, is_full, pop;

  assign blk         = fetch_rdata;
  assign fetch_ready = (free >= CW'(FETCH_HW)) && !redirect;
  // A response whose address is not the expected block is stale and dropped.
  assign accept      = fetch_valid && fetch_ready && (fetch_pc == expect_pc);
  assign is_full     = (h0[1:0] == RVC_FULL);
  assign instr_valid = is_full ? (count >= CW'(2)) : (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign pop_n       = !pop ? 2'd0 : (is_full ? 2'd2 : 2'd1);
  assign push_n      = accept ? (NW'(FETCH_HW) - NW'(skip)) : '0;

  // Compact the block so halfword 'skip' lands in the first write slot.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < FETCH_HW; i++) begin
      for (int j = 0; j < FETCH_HW; j++) begin
        if (j == i + int'(skip)) push_data[i] = blk[j];
      end
    end
  end

  halfword_fifo #(.DEPTH_HW(DEPTH_HW), .FETCH_HW(FETCH_HW)) u_fifo (
    .clk       (clk),
    .clear     (rst | redirect),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .h0        (h0),
    .h1        (h1),
    .count     (count),
    .free      (free)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head_pc   <= '0;
      expect_pc <= '0;
      skip      <= '0;
    end else if (redirect) begin
      head_pc   <= redirect_pc;
      expect_pc <= {redirect_pc[31:BB], {BB{1'b0}}};
      skip      <= redirect_pc[BB-1:1];
    end else begin
      if (pop) head_pc <= head_pc + (is_full ? 32'd4 : 32'd2);
      if (accept) begin
        expect_pc <= expect_pc + 32'(FETCH_HW * 2);
        skip      <= '0;
      end
    end
  end

  // Empty FIFO shows the all-ones idle pattern; a lone upper half is filled too.
  always_comb begin
    instr      = {IR_FILL_HW, IR_FILL_HW};
    instr_is_c = 1'b0;
    if (count != '0) begin
      instr_is_c = !is_full;
      instr      = {(is_full && count >= CW'(2)) ? h1 : IR_FILL_HW, h0};
    end
  end

  assign instr_pc = head_pc;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed checks on a 32-bit-fetch instance, then a random program streamed
// through a 64-bit-fetch instance against a program-order reference list.
module tb_fetch_align_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: FETCH_HW=2
  logic        a_redirect = 0, a_fetch_valid = 0, a_instr_ready = 0;
  logic [31:0] a_redirect_pc = 0, a_fetch_pc = 0;
  logic [31:0] a_fetch_rdata = 0;
  logic        a_fetch_ready, a_instr_valid, a_instr_is_c;
  logic [31:0] a_instr, a_instr_pc;

  // Instance B: FETCH_HW=4
  logic        b_redirect = 0, b_fetch_valid = 0, b_instr_ready = 0;
  logic [31:0] b_redirect_pc = 0, b_fetch_pc = 0;
  logic [63:0] b_fetch_rdata = 0;
  logic        b_fetch_ready, b_instr_valid, b_instr_is_c;
  logic [31:0] b_instr, b_instr_pc;

  fetch_align_buffer #(.FETCH_HW(2), .DEPTH_HW(8)) dut_a (
    .clk(clk), .rst(rst), .redirect(a_redirect), .redirect_pc(a_redirect_pc),
    .fetch_valid(a_fetch_valid), .fetch_ready(a_fetch_ready), .fetch_pc(a_fetch_pc),
    .fetch_rdata(a_fetch_rdata), .instr_valid(a_instr_valid), .instr_ready(a_instr_ready),
    .instr(a_instr), .instr_pc(a_instr_pc), .instr_is_c(a_instr_is_c)
  );

  fetch_align_buffer #(.FETCH_HW(4), .DEPTH_HW(8)) dut_b (
    .clk(clk), .rst(rst), .redirect(b_redirect), .redirect_pc(b_redirect_pc),
    .fetch_valid(b_fetch_valid), .fetch_ready(b_fetch_ready), .fetch_pc(b_fetch_pc),
    .fetch_rdata(b_fetch_rdata), .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
    .instr(b_instr), .instr_pc(b_instr_pc), .instr_is_c(b_instr_is_c)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference program for instance B
  localparam int NHW = 256;
  localparam int NBLK = NHW / 4;
  localparam logic [31:0] BASE = 32'h1000;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_c;
  } exp_t;
  logic [15:0] pmem [NHW];
  exp_t        exp_q [$];

  initial begin
    // ---- reset state ----
    rst = 1; tick(); rst = 0; #1;
    chk("rst_valid", a_instr_valid, 0);
    chk("rst_pc", a_instr_pc, 0);
    chk("rst_is_c", a_instr_is_c, 0);
    chk("rst_instr", a_instr, 32'hffffffff);
    chk("rst_fready", a_fetch_ready, 1);

    // ---- redirect to 0x100, mixed compressed block ----
    a_redirect = 1; a_redirect_pc = 32'h100; #1;
    chk("redir_fready_low", a_fetch_ready, 0);
    tick(); a_redirect = 0; #1;
    chk("redir_empty", a_instr_valid, 0);
    a_fetch_valid = 1; a_fetch_pc = 32'h100; a_fetch_rdata = {16'h4501, 16'h4581};
    tick(); a_fetch_valid = 0; a_instr_ready = 1; #1;
    chk("t1_valid0", a_instr_valid, 1);
    chk("t1_instr0", a_instr, 32'hffff4581);
    chk("t1_pc0", a_instr_pc, 32'h100);
    chk("t1_isc0", a_instr_is_c, 1);
    tick(); #1;
    chk("t1_valid1", a_instr_valid, 1);
    chk("t1_instr1", a_instr, 32'hffff4501);
    chk("t1_pc1", a_instr_pc, 32'h102);
    chk("t1_isc1", a_instr_is_c, 1);
    tick(); #1;
    chk("t1_drained", a_instr_valid, 0);
    a_instr_ready = 0;

    // ---- halfword-aligned redirect, split instruction ----
    a_redirect = 1; a_redirect_pc = 32'h202; #1;
    tick(); a_redirect = 0;
    a_fetch_valid = 1; a_fetch_pc = 32'h200; a_fetch_rdata = {16'h0513, 16'h0001}; #1;
    tick(); a_fetch_valid = 0; #1;
    chk("t2_split_valid", a_instr_valid, 0);
    chk("t2_split_pc", a_instr_pc, 32'h202);
    a_fetch_valid = 1; a_fetch_pc = 32'h204; a_fetch_rdata = {16'h0000, 16'h0010}; #1;
    tick(); a_fetch_valid = 0; a_instr_ready = 1; #1;
    chk("t2_valid", a_instr_valid, 1);
    chk("t2_instr", a_instr, 32'h00100513);
    chk("t2_pc", a_instr_pc, 32'h202);
    chk("t2_isc", a_instr_is_c, 0);
    tick(); #1;
    chk("t2_instr1", a_instr, 32'hffff0000);
    chk("t2_pc1", a_instr_pc, 32'h206);
    chk("t2_isc1", a_instr_is_c, 1);
    tick(); a_instr_ready = 0; #1;
    chk("t2_drained", a_instr_valid, 0);

    // ---- full buffer back-pressure ----
    a_redirect = 1; a_redirect_pc = 32'h300; #1;
    tick(); a_redirect = 0;
    for (int k = 0; k < 4; k++) begin
      a_fetch_valid = 1; a_fetch_pc = 32'h300 + 32'(4 * k); a_fetch_rdata = {16'h4501, 16'h4581}; #1;
      chk("t3_fready_open", a_fetch_ready, 1);
      tick();
    end
    a_fetch_pc = 32'h310; #1;
    chk("t3_full", a_fetch_ready, 0);
    tick(); #1;
    chk("t3_full_hold", a_fetch_ready, 0);
    chk("t3_head_hold", a_instr_pc, 32'h300);
    a_instr_ready = 1; #1;
    chk("t3_drain0", a_fetch_ready, 0);
    tick(); #1;
    chk("t3_free1", a_fetch_ready, 0);
    tick(); #1;
    chk("t3_free2", a_fetch_ready, 1);
    chk("t3_head", a_instr_pc, 32'h304);
    a_fetch_valid = 0; a_instr_ready = 0;
    tick();

    // ---- stale response ----
    a_redirect = 1; a_redirect_pc = 32'h400;
    a_fetch_valid = 1; a_fetch_pc = 32'h108; a_fetch_rdata = {16'h1111, 16'h2221}; #1;
    tick(); a_redirect = 0; #1;
    chk("t4_stale_ready", a_fetch_ready, 1);
    tick(); a_fetch_valid = 0; #1;
    chk("t4_stale_dropped", a_instr_valid, 0);
    chk("t4_stale_free", a_fetch_ready, 1);
    a_fetch_valid = 1; a_fetch_pc = 32'h400; a_fetch_rdata = {16'h4501, 16'h4581}; #1;
    tick(); a_fetch_valid = 0; #1;
    chk("t4_valid", a_instr_valid, 1);
    chk("t4_instr", a_instr, 32'hffff4581);
    chk("t4_pc", a_instr_pc, 32'h400);

    // ---- redirect with concurrent pop and push ----
    a_instr_ready = 1; a_fetch_valid = 1; a_fetch_pc = 32'h404; a_fetch_rdata = {16'h3331, 16'h4441};
    a_redirect = 1; a_redirect_pc = 32'h500; #1;
    chk("t5_pre_valid", a_instr_valid, 1);
    tick(); a_redirect = 0; a_fetch_valid = 0; a_instr_ready = 0; #1;
    chk("t5_valid", a_instr_valid, 0);
    chk("t5_head", a_instr_pc, 32'h500);
    a_fetch_valid = 1; a_fetch_pc = 32'h500; a_fetch_rdata = {16'h4501, 16'h4581}; #1;
    tick(); a_fetch_valid = 0; #1;
    chk("t5_instr", a_instr, 32'hffff4581);
    chk("t5_pc", a_instr_pc, 32'h500);

    // ---- reset mid-operation with an in-flight handshake ----
    rst = 1; a_fetch_valid = 1; a_fetch_pc = 32'h504; a_fetch_rdata = {16'h4501, 16'h4581};
    a_instr_ready = 1; #1;
    tick(); rst = 0; a_fetch_valid = 0; a_instr_ready = 0; #1;
    chk("t6_valid", a_instr_valid, 0);
    chk("t6_pc", a_instr_pc, 0);
    chk("t6_instr", a_instr, 32'hffffffff);
    chk("t6_fready", a_fetch_ready, 1);
    chk("t6_b_valid", b_instr_valid, 0);

    // ---- random program through FETCH_HW=4 ----
    begin
      int s, idx;
      logic [15:0] hw;
      for (int i = 0; i < NHW; i++) pmem[i] = 16'($urandom);
      s = $urandom_range(0, 3);
      idx = s;
      while (idx < NHW) begin
        hw = 16'($urandom);
        if (idx == NHW - 1 || $urandom_range(0, 1) == 0) begin
          hw[1:0] = 2'($urandom_range(0, 2));
          pmem[idx] = hw;
          exp_q.push_back('{{16'hffff, hw}, BASE + 32'(2 * idx), 1'b1});
          idx += 1;
        end else begin
          hw[1:0] = 2'b11;
          pmem[idx] = hw;
          exp_q.push_back('{{pmem[idx+1], hw}, BASE + 32'(2 * idx), 1'b0});
          idx += 2;
        end
      end

      b_redirect = 1; b_redirect_pc = BASE + 32'(2 * s); #1;
      tick(); b_redirect = 0;
      begin
        int bi;
        bit stale;
        exp_t e;
        bi = 0;
        for (int cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
          b_instr_ready = ($urandom_range(0, 3) != 0);
          b_fetch_valid = 0;
          stale = 0;
          if (bi < NBLK && $urandom_range(0, 3) != 0) begin
            b_fetch_valid = 1;
            if ($urandom_range(0, 7) == 0) begin
              stale = 1;
              b_fetch_pc = 32'h9000 + 32'(8 * bi);
              b_fetch_rdata = {$urandom, $urandom};
            end else begin
              b_fetch_pc = BASE + 32'(8 * bi);
              b_fetch_rdata = {pmem[4*bi+3], pmem[4*bi+2], pmem[4*bi+1], pmem[4*bi]};
            end
          end
          #1;
          if (b_instr_valid && b_instr_ready) begin
            e = exp_q.pop_front();
            chk("rand_instr", b_instr, e.instr);
            chk("rand_pc", b_instr_pc, e.pc);
            chk("rand_is_c", b_instr_is_c, e.is_c);
          end
          if (b_fetch_valid && b_fetch_ready && !stale) bi++;
          tick();
        end
        b_fetch_valid = 0; b_instr_ready = 0;
        chk("rand_remaining", exp_q.size(), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
